// File: rtl/seg7_scan_decoder.sv
// Observes a multiplexed, active-low 7-segment display bus and recovers the displayed BCD
// digits. Each digit position is captured only after its pattern has been stable for a
// number of samples. A completed frame is offered on a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   seg_n      segment lines, active low, bit0=a .. bit6=g
//   dig_sel    one-hot digit strobe, active high
//   frame_bcd  recovered digits, digit i in [4i+3:4i], 4'hF for an undecodable pattern
//   frame_vld  frame_bcd/frame_err hold a complete frame
//   frame_rdy  consumer accepts the frame when frame_vld & frame_rdy
//   frame_err  at least one digit in the frame is undecodable
module seg7_scan_decoder #(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE_CYC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_n,
  input  logic [NDIG-1:0]   dig_sel,
  output logic [4*NDIG-1:0] frame_bcd,
  output logic              frame_vld,
  input  logic              frame_rdy,
  output logic              frame_err
);

  localparam int unsigned CntW = $clog2(STABLE_CYC + 1);
  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYC);

  typedef enum logic [0:0] {StCollect, StPresent} state_e;

  state_e            state_q, state_d;
  logic [6:0]        s_seg_q, p_seg_q;
  logic [NDIG-1:0]   s_sel_q, p_sel_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NDIG-1:0]   mask_q, mask_d;
  logic [4*NDIG-1:0] digits_q, digits_d;

  logic            sel_onehot;
  logic            same;
  logic            capture;
  logic [IdxW-1:0] idx;
  logic [3:0]      dec;

  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    logic [3:0] v;
    unique case (s)
      7'b1000000: v = 4'd0;
      7'b1111001: v = 4'd1;
      7'b0100100: v = 4'd2;
      7'b0110000: v = 4'd3;
      7'b0011001: v = 4'd4;
      7'b0010010: v = 4'd5;
      7'b0000010: v = 4'd6;
      7'b1111000: v = 4'd7;
      7'b0000000: v = 4'd8;
      7'b0010000: v = 4'd9;
      default:    v = 4'hF;
    endcase
    return v;
  endfunction

  // Input registers; p_* keeps the previous sample for the stability compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg_q <= 7'h7F;
      s_sel_q <= '0;
      p_seg_q <= 7'h7F;
      p_sel_q <= '0;
    end else begin
      s_seg_q <= seg_n;
      s_sel_q <= dig_sel;
      p_seg_q <= s_seg_q;
      p_sel_q <= s_sel_q;
    end
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (s_sel_q[i]) idx = IdxW'(i);
    end
  end

  assign sel_onehot = $onehot(s_sel_q);
  assign same       = (s_seg_q == p_seg_q) && (s_sel_q == p_sel_q);
  assign dec        = seg_decode(s_seg_q);

  // cnt counts one-hot samples of the current run (first sample of a run loads 1), so a
  // capture happens on the edge it reaches STABLE_CYC. Only the edge that reaches the
  // limit captures; a saturated run does not re-capture.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StPresent || !sel_onehot) begin
      cnt_d = '0;
    end else if (!same) begin
      cnt_d = CntW'(1);
    end else if (cnt_q < CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign capture = (state_q == StCollect) && sel_onehot && (cnt_d == CntMax) &&
                   !(same && (cnt_q == CntMax));

  always_comb begin
    digits_d = digits_q;
    mask_d   = mask_q;
    if (capture) begin
      digits_d[4*idx +: 4] = dec;
      mask_d[idx]          = 1'b1;
    end
    if (state_q == StPresent && frame_rdy) begin
      mask_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mask_q   <= '0;
      digits_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      digits_q <= digits_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StCollect;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: if (&mask_q) state_d = StPresent;
      StPresent: if (frame_rdy) state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  // FSM outputs; digits cannot change in StPresent, so bcd/err are frozen there.
  always_comb begin
    frame_vld = (state_q == StPresent);
    frame_bcd = digits_q;
    frame_err = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (digits_q[4*i +: 4] == 4'hF) frame_err = 1'b1;
    end
  end

endmodule
